seq_magnitude_compare: RTL

//   Parametrised multi-cycle magnitude comparator. Generalises the equality compare to

---
 rtl/seq_magnitude_compare.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_magnitude_compare.sv
// Multi-cycle WIDTH-bit magnitude compare, CHUNK bits per cycle, MSB first.
// Signed mode flips the sign bits so the unsigned chunk compare orders correctly.
module seq_magnitude_compare #(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             mis_q, mis_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] ax, bx;
  logic [CHUNK-1:0] ca, cb;
  logic             c_eq, c_gt;
  logic             mis_n, dir_n;
  logic             finish;

  always_comb begin
    ax = a_q;
    bx = b_q;
    ax[WIDTH-1] = a_q[WIDTH-1] ^ sgn_q;
    bx[WIDTH-1] = b_q[WIDTH-1] ^ sgn_q;
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        ca = ax[i*CHUNK +: CHUNK];
        cb = bx[i*CHUNK +: CHUNK];
      end
    end
    c_eq = (ca == cb);
    c_gt = (ca > cb);
    // first mismatch owns the direction
    mis_n = mis_q | ~c_eq;
    dir_n = mis_q ? dir_q : c_gt;
    finish = (~c_eq && (EARLY_EXIT != 0)) || (idx_q == '0);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    mis_d   = mis_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          idx_d   = LAST;
          mis_d   = 1'b0;
          dir_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (finish) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          eq_d    = ~mis_n;
          gt_d    = mis_n & dir_n;
          lt_d    = mis_n & ~dir_n;
        end else begin
          idx_d = idx_q - 1'b1;
          mis_d = mis_n;
          dir_d = dir_n;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= LAST;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign aeqb = eq_q;
  assign agtb = gt_q;
  assign altb = lt_q;

endmodule
